// File: rtl/alu_sequencer.sv
// Issue-side controller for the multi-cycle ALU: one operation in flight, operands held
// stable while the ALU works, result/flags captured and returned with a WAIT-cycle count.
module alu_sequencer #(
  parameter int unsigned P_TIMEOUT = 64
) (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_req_valid,
  output logic        O_req_ready,
  input  logic [4:0]  I_req_op,
  input  logic [31:0] I_req_s1,
  input  logic [31:0] I_req_s2,
  output logic        O_alu_en,
  output logic [4:0]  O_alu_op,
  output logic [31:0] O_alu_s1,
  output logic [31:0] O_alu_s2,
  output logic        O_alu_flush,
  input  logic        I_alu_busy,
  input  logic [31:0] I_alu_data,
  input  logic        I_alu_lt,
  input  logic        I_alu_ltu,
  input  logic        I_alu_eq,
  output logic        O_resp_valid,
  input  logic        I_resp_ready,
  output logic [31:0] O_resp_data,
  output logic        O_resp_lt,
  output logic        O_resp_ltu,
  output logic        O_resp_eq,
  output logic        O_resp_err,
  output logic [7:0]  O_resp_cycles
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(P_TIMEOUT);

  state_t      state_r, state_next_s;
  logic [4:0]  op_r;
  logic [31:0] s1_r, s2_r;
  logic [7:0]  cnt_r, cnt_inc_s;
  logic        done_s, timeout_s;
  logic        alu_en_r, resp_valid_r;
  logic [31:0] resp_data_r;
  logic        resp_lt_r, resp_ltu_r, resp_eq_r, resp_err_r;
  logic [7:0]  resp_cycles_r;

  // WAIT-cycle number of the current cycle (1 = first WAIT cycle), plus completion/timeout decode
  always_comb begin
    cnt_inc_s = (cnt_r == 8'hFF) ? cnt_r : (cnt_r + 8'd1);
    done_s    = (state_r == ST_WAIT) && !I_alu_busy;
    timeout_s = (state_r == ST_WAIT) && I_alu_busy && (cnt_inc_s == TIMEOUT_C);
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (I_req_valid) state_next_s = ST_ISSUE;
        else             state_next_s = ST_IDLE;
      end
      ST_ISSUE: state_next_s = ST_WAIT;
      ST_WAIT: begin
        if (done_s || timeout_s) state_next_s = ST_RESP;
        else                     state_next_s = ST_WAIT;
      end
      ST_RESP: begin
        if (I_resp_ready) state_next_s = ST_IDLE;
        else              state_next_s = ST_RESP;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, holding registers, WAIT counter and response capture
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_r       <= ST_IDLE;
      op_r          <= 5'd0;
      s1_r          <= 32'd0;
      s2_r          <= 32'd0;
      cnt_r         <= 8'd0;
      alu_en_r      <= 1'b0;
      resp_valid_r  <= 1'b0;
      resp_data_r   <= 32'd0;
      resp_lt_r     <= 1'b0;
      resp_ltu_r    <= 1'b0;
      resp_eq_r     <= 1'b0;
      resp_err_r    <= 1'b0;
      resp_cycles_r <= 8'd0;
    end else begin
      state_r      <= state_next_s;
      // Enable/valid are registered images of the state being entered
      alu_en_r     <= (state_next_s == ST_ISSUE);
      resp_valid_r <= (state_next_s == ST_RESP);
      if ((state_r == ST_IDLE) && I_req_valid) begin
        op_r <= I_req_op;
        s1_r <= I_req_s1;
        s2_r <= I_req_s2;
      end
      if (state_r == ST_ISSUE) begin
        cnt_r <= 8'd0;
      end else if (state_r == ST_WAIT) begin
        cnt_r <= cnt_inc_s;
      end
      if (done_s) begin
        resp_data_r   <= I_alu_data;
        resp_lt_r     <= I_alu_lt;
        resp_ltu_r    <= I_alu_ltu;
        resp_eq_r     <= I_alu_eq;
        resp_err_r    <= 1'b0;
        resp_cycles_r <= cnt_inc_s;
      end else if (timeout_s) begin
        resp_data_r   <= 32'd0;
        resp_lt_r     <= 1'b0;
        resp_ltu_r    <= 1'b0;
        resp_eq_r     <= 1'b0;
        resp_err_r    <= 1'b1;
        resp_cycles_r <= cnt_inc_s;
      end
    end
  end

  // Flush must be seen by the ALU's synchronous reset at the WAIT->RESP edge itself
  assign O_alu_flush   = timeout_s;
  assign O_req_ready   = (state_r == ST_IDLE);
  assign O_alu_en      = alu_en_r;
  assign O_alu_op      = op_r;
  assign O_alu_s1      = s1_r;
  assign O_alu_s2      = s2_r;
  assign O_resp_valid  = resp_valid_r;
  assign O_resp_data   = resp_data_r;
  assign O_resp_lt     = resp_lt_r;
  assign O_resp_ltu    = resp_ltu_r;
  assign O_resp_eq     = resp_eq_r;
  assign O_resp_err    = resp_err_r;
  assign O_resp_cycles = resp_cycles_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer with a behavioural ALU stub whose
// busy duration is chosen per operation.
module tb_alu_sequencer;

  localparam int P_TO = 40;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_SLL   = 5'd2;
  localparam logic [4:0] OP_AND   = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_DIV   = 5'd5;
  localparam logic [4:0] OP_DIVU  = 5'd6;
  localparam logic [4:0] OP_MULHU = 5'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [4:0]  req_op;
  logic [31:0] req_s1, req_s2;
  logic        alu_en, alu_flush, alu_busy;
  logic [4:0]  alu_op;
  logic [31:0] alu_s1, alu_s2, alu_data;
  logic        alu_lt, alu_ltu, alu_eq;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic        resp_lt, resp_ltu, resp_eq, resp_err;
  logic [7:0]  resp_cycles;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.P_TIMEOUT(P_TO)) dut (
    .I_clk(clk), .I_reset(rst),
    .I_req_valid(req_valid), .O_req_ready(req_ready),
    .I_req_op(req_op), .I_req_s1(req_s1), .I_req_s2(req_s2),
    .O_alu_en(alu_en), .O_alu_op(alu_op), .O_alu_s1(alu_s1), .O_alu_s2(alu_s2),
    .O_alu_flush(alu_flush), .I_alu_busy(alu_busy), .I_alu_data(alu_data),
    .I_alu_lt(alu_lt), .I_alu_ltu(alu_ltu), .I_alu_eq(alu_eq),
    .O_resp_valid(resp_valid), .I_resp_ready(resp_ready),
    .O_resp_data(resp_data), .O_resp_lt(resp_lt), .O_resp_ltu(resp_ltu),
    .O_resp_eq(resp_eq), .O_resp_err(resp_err), .O_resp_cycles(resp_cycles)
  );

  function automatic logic [31:0] ref_result(logic [4:0] op, logic [31:0] a, logic [31:0] b);
    logic [63:0] p;
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLL:  return a << b[4:0];
      OP_AND:  return a & b;
      OP_XOR:  return a ^ b;
      OP_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return $signed(a) / $signed(b);
      end
      OP_MULHU: begin
        p = {32'd0, a} * {32'd0, b};
        return p[63:32];
      end
      default: return 32'd0;
    endcase
  endfunction

  // Number of cycles the stub ALU holds busy after the enable edge
  function automatic int op_latency(logic [4:0] op, logic [31:0] b);
    case (op)
      OP_SLL:          return int'(b[4:0]) + 1;
      OP_DIV, OP_DIVU: return (b == 32'd0) ? 0 : 33;
      OP_MULHU:        return 33;
      default:         return 0;
    endcase
  endfunction

  // ---------------- ALU stub ----------------
  int          lat_q = 0;
  int          stub_cnt;
  logic        stub_busy;
  logic [31:0] stub_data;
  logic        stub_lt, stub_ltu, stub_eq;
  logic        stable_ok;
  logic [4:0]  op_c;
  logic [31:0] s1_c, s2_c;
  int          en_total = 0;
  int          flush_total = 0;

  assign alu_busy = stub_busy;
  assign alu_data = stub_data;
  assign alu_lt   = stub_lt;
  assign alu_ltu  = stub_ltu;
  assign alu_eq   = stub_eq;

  always @(posedge clk) begin
    if (alu_en) en_total <= en_total + 1;
    if (alu_flush) flush_total <= flush_total + 1;
  end

  always @(posedge clk) begin
    if (rst) begin
      stub_busy <= 1'b0;
      stub_cnt  <= 0;
      stub_data <= 32'd0;
      stub_lt   <= 1'b0;
      stub_ltu  <= 1'b0;
      stub_eq   <= 1'b0;
      stable_ok <= 1'b1;
    end else if (alu_flush) begin
      stub_busy <= 1'b0;
    end else if (alu_en) begin
      op_c <= alu_op; s1_c <= alu_s1; s2_c <= alu_s2;
      stable_ok <= 1'b1;
      if (lat_q == 0) begin
        stub_busy <= 1'b0;
        stub_data <= ref_result(alu_op, alu_s1, alu_s2);
        stub_lt   <= $signed(alu_s1) < $signed(alu_s2);
        stub_ltu  <= alu_s1 < alu_s2;
        stub_eq   <= alu_s1 == alu_s2;
      end else begin
        stub_busy <= 1'b1;
        stub_cnt  <= lat_q;
        stub_data <= $urandom;
        {stub_lt, stub_ltu, stub_eq} <= 3'($urandom_range(0, 7));
      end
    end else if (stub_busy) begin
      if (alu_op != op_c || alu_s1 != s1_c || alu_s2 != s2_c) stable_ok <= 1'b0;
      if (stub_cnt == 1) begin
        stub_busy <= 1'b0;
        stub_data <= ref_result(alu_op, alu_s1, alu_s2);
        stub_lt   <= $signed(alu_s1) < $signed(alu_s2);
        stub_ltu  <= alu_s1 < alu_s2;
        stub_eq   <= alu_s1 == alu_s2;
      end else begin
        stub_cnt  <= stub_cnt - 1;
        stub_data <= $urandom;
        {stub_lt, stub_ltu, stub_eq} <= 3'($urandom_range(0, 7));
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input int hold);
    logic        exp_err;
    int          exp_cyc;
    logic [31:0] exp_data;
    int          n;
    int          e0, f0;
    logic        no_accept, held_ok;
    logic [31:0] d0;
    lat_q    = lat;
    exp_err  = (lat >= P_TO);
    exp_cyc  = exp_err ? P_TO : lat + 1;
    exp_data = exp_err ? 32'd0 : ref_result(op, a, b);
    e0 = en_total;
    f0 = flush_total;
    chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_op = op; req_s1 = a; req_s2 = b;
    @(negedge clk);
    n = 1;
    no_accept = 1'b1;
    while (!resp_valid && n < 300) begin
      if (req_ready) no_accept = 1'b0;
      req_valid = 1'($urandom_range(0, 1));
      req_op = 5'($urandom); req_s1 = $urandom; req_s2 = $urandom;
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    chk("resp_seen", {63'd0, resp_valid}, 64'd1);
    chk("latency", 64'(n), 64'(2 + exp_cyc));
    chk("data", {32'd0, resp_data}, {32'd0, exp_data});
    chk("err", {63'd0, resp_err}, {63'd0, exp_err});
    chk("cycles", {56'd0, resp_cycles}, 64'(exp_cyc));
    if (!exp_err) begin
      chk("flags", {61'd0, resp_lt, resp_ltu, resp_eq},
          {61'd0, $signed(a) < $signed(b), a < b, a == b});
    end else begin
      chk("err_data_zero", {32'd0, resp_data}, 64'd0);
    end
    chk("en_pulses", 64'(en_total - e0), 64'd1);
    chk("flush_pulses", 64'(flush_total - f0), {63'd0, exp_err});
    chk("alu_hold", {27'd0, alu_op, alu_s1}, {27'd0, op, a});
    chk("alu_hold_s2", {32'd0, alu_s2}, {32'd0, b});
    chk("alu_stable", {63'd0, stable_ok}, 64'd1);
    chk("no_accept", {63'd0, no_accept}, 64'd1);
    d0 = resp_data;
    held_ok = 1'b1;
    resp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!resp_valid || resp_data != d0 || req_ready) held_ok = 1'b0;
    end
    chk("resp_hold", {63'd0, held_ok}, 64'd1);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_drop", {63'd0, resp_valid}, 64'd0);
    chk("back_idle", {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    logic [4:0]  rop;
    logic [31:0] ra, rb;
    int          f0;
    rst = 1'b1; req_valid = 1'b0; req_op = 5'd0; req_s1 = 32'd0; req_s2 = 32'd0;
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_ctl", {60'd0, alu_en, alu_flush, resp_valid, resp_err}, 64'd0);
    chk("rst_data", {24'd0, resp_cycles, resp_data}, 64'd0);
    chk("rst_hold", {27'd0, alu_op, alu_s1}, 64'd0);
    chk("rst_flags", {61'd0, resp_lt, resp_ltu, resp_eq}, 64'd0);

    run_op(OP_ADD, 32'd5, 32'd7, op_latency(OP_ADD, 32'd7), 0);
    run_op(OP_SLL, 32'd1, 32'd4, op_latency(OP_SLL, 32'd4), 0);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, op_latency(OP_DIV, 32'd2), 0);
    run_op(OP_DIVU, 32'h1234_5678, 32'd0, op_latency(OP_DIVU, 32'd0), 0);
    run_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, op_latency(OP_MULHU, 32'hFFFF_FFFF), 10);
    run_op(OP_ADD, 32'd3, 32'd4, 255, 1);
    run_op(OP_XOR, 32'hA5A5_0000, 32'h0000_5A5A, P_TO - 1, 0);
    run_op(OP_SUB, 32'd1, 32'd9, P_TO, 0);

    // Reset in WAIT cycle 3 of a DIV
    f0 = flush_total;
    lat_q = 33;
    req_valid = 1'b1; req_op = OP_DIV; req_s1 = 32'd100; req_s2 = 32'd7;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_mid_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_mid_flush", 64'(flush_total - f0), 64'd0);
    run_op(OP_ADD, 32'd1, 32'd1, op_latency(OP_ADD, 32'd1), 0);

    for (int k = 0; k < 30; k++) begin
      rop = 5'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      run_op(rop, ra, rb,
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 50)) : op_latency(rop, rb),
             int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Issue-side controller for the multi-cycle `alu` execution unit. It accepts one operation at a time over a valid/ready request port, and drives the ALU's enable/opcode/operand inputs. It holds those inputs stable for the whole operation, tracks the ALU busy handshake and captures result and flags. It then returns them over a valid/ready response port with a latency count, and recovers from a hung ALU with a watchdog.

## Interface
- P_TIMEOUT, 64: max WAIT cycles before the watchdog fires (2..255).
- I_clk  in  1  clock; all logic on rising edge.
- I_reset  in  1  synchronous, active-high reset.
- I_req_valid  in  1  request present.
- O_req_ready  out  1  sequencer can accept a request.
- I_req_op  in  5  ALU opcode (`ALUOP_*` from aludefs).
- I_req_s1, I_req_s2  in  32  operands.
- O_alu_en  out  1  ALU enable.
- O_alu_op  out  5  ALU opcode.
- O_alu_s1, O_alu_s2  out  32  ALU operands.
- O_alu_flush  out  1  one-cycle pulse; the top level ORs it into the ALU reset.
- I_alu_busy  in  1  ALU busy.
- I_alu_data  in  32  ALU result.
- I_alu_lt, I_alu_ltu, I_alu_eq  in  1  registered ALU compare flags.
- O_resp_valid  out  1  response present.
- I_resp_ready  in  1  consumer accepts the response.
- O_resp_data  out  32  result.
- O_resp_lt, O_resp_ltu, O_resp_eq  out  1  captured flags.
- O_resp_err  out  1  watchdog timeout; data is 0.
- O_resp_cycles  out  8  cycles spent in WAIT, saturating at 255.

## Operation
- States: IDLE, ISSUE, WAIT, RESP (2-bit). Reset state is IDLE.
- IDLE:
  - O_req_ready=1.
  - On I_req_valid, latch op/s1/s2 into holding registers and go to ISSUE.
- ISSUE:
  - O_alu_en=1 for exactly this cycle.
  - Clear the WAIT counter and go to WAIT.
- WAIT:
  - O_alu_en=0. Increment the counter every cycle.
  - If I_alu_busy=0: capture I_alu_data, the flags and the counter value, set err=0, and go to RESP.
  - Else, if the counter equals P_TIMEOUT: pulse O_alu_flush, set data=0 and err=1, and go to RESP.
- RESP:
  - O_resp_valid=1. Response outputs stay stable until accepted.
  - On I_resp_ready, go to IDLE. No bypass: a new request is accepted one cycle later.
- O_alu_op, O_alu_s1 and O_alu_s2 always come from the holding registers. They are constant from ISSUE until the next accepted request, because the ALU re-reads the opcode and operands on every busy cycle and in its final sign-fixup step.
- Single- vs multi-cycle ops need no decode. In the first WAIT cycle, busy=0 means the result was written at the enable edge: simple ops, divide-by-zero and the REM corner cases.
- A busy 1→0 transition is concurrent with the final result write, so data is valid in the first cycle busy reads 0.
- O_resp_cycles: a counter value of 1 means the first WAIT cycle; it saturates at 255.
- O_req_ready is 0 in ISSUE, WAIT and RESP; requests in those states are not accepted.

## Timing
- Reset values:
  - state IDLE.
  - O_req_ready=1 (combinational from IDLE).
  - O_alu_en=0, O_alu_flush=0, O_resp_valid=0, O_resp_err=0.
  - Holding registers, O_resp_data and O_resp_cycles = 0; all flags 0.
- Reset mid-operation: abandon the operation and return to IDLE next cycle. No response is produced and no flush pulse is issued, because the ALU shares I_reset.
- Latency from request accept edge to O_resp_valid = 2 + resp_cycles cycles. Examples:
  - ADD: resp_cycles=1.
  - Shift by n: resp_cycles=n+2.
  - Multi-cycle MUL/DIV: resp_cycles=34.
- Maximum WAIT length is P_TIMEOUT cycles. The flush pulse is coincident with the WAIT→RESP edge.
- Back-to-back operations: minimum 4 cycles per operation (IDLE, ISSUE, WAIT, RESP with ready=1).

## Test plan
- ADD 5+7 with I_resp_ready=1 → single en pulse; resp_data=12, cycles=1, err=0; valid 3 cycles after accept.
- SLL 1 by 4 with the real ALU → busy high 5 cycles; resp_data=0x10, cycles=6; op/s1/s2 constant throughout.
- DIV 0xFFFFFFF9 / 2 → resp_data=0xFFFFFFFD, cycles=34. Then DIVU x/0 → resp_data=0xFFFFFFFF, cycles=1.
- MULHU 0xFFFFFFFF * 0xFFFFFFFF with I_resp_ready held 0 for 10 cycles → data 0xFFFFFFFE stable and valid held; req_ready=0 until accepted.
- Stub ALU with busy stuck at 1, P_TIMEOUT=8 → flush pulse for 1 cycle at WAIT cycle 8; resp err=1, data=0, cycles=8.
- I_reset asserted in WAIT cycle 3 of a DIV → next cycle IDLE, resp_valid=0, req_ready=1. A following ADD 1+1 returns 2.
